// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Drives the single write port of the register file. It merges two result
//   sources into that port:
//     - the ALU result, which is unbuffered and always wins the write slot;
//     - the load result, which is buffered in a DEPTH-entry FIFO and drains
//       on any edge where the ALU is not writing.
//   Writes to x0 are dropped. A buffered load is killed (its live bit is
//   cleared) when a younger ALU write targets the same rd. Pending-write
//   flags let decode stall reads of registers that have not been written yet.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   alu_valid/alu_rd/alu_data     ALU result (no backpressure)
//   ld_valid/ld_ready/ld_rd/ld_data  load result handshake into the FIFO
//   rf_write/rf_write_add/rf_data registered register-file write port
//   chk_add1/chk_add2             decode source addresses to check
//   chk_pending1/chk_pending2     a write to that address is outstanding
//   fifo_count                    occupied FIFO slots (killed ones included)

module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       rf_write,
    output logic [ADDR_W-1:0]          rf_write_add,
    output logic [DATA_W-1:0]          rf_data,
    input  logic [ADDR_W-1:0]          chk_add1,
    input  logic [ADDR_W-1:0]          chk_add2,
    output logic                       chk_pending1,
    output logic                       chk_pending2,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_add_q, rf_add_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic alu_wr;
    logic push;
    logic pop;

    // Registered count only: no combinational path from either valid input.
    assign ld_ready   = !rst && (count_q < CW'(DEPTH));
    assign fifo_count = count_q;

    assign rf_write     = rf_write_q;
    assign rf_write_add = rf_add_q;
    assign rf_data      = rf_data_q;

    always_comb begin
        alu_wr = alu_valid && (alu_rd != '0);
        // A load to x0 completes the handshake but never occupies a slot.
        push   = ld_valid && ld_ready && (ld_rd != '0);
        pop    = !alu_wr && (count_q != '0);

        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_wr && (rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end
        // Popped slots lose their live bit so pending checks never see stale
        // entries; the push comes last so a same-edge load is not killed.
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        rf_write_d = 1'b0;
        rf_add_d   = rf_add_q;
        rf_data_d  = rf_data_q;
        if (alu_wr) begin
            rf_write_d = 1'b1;
            rf_add_d   = alu_rd;
            rf_data_d  = alu_data;
        end else if (pop && live_q[rd_ptr_q]) begin
            rf_write_d = 1'b1;
            rf_add_d   = rd_q[rd_ptr_q];
            rf_data_d  = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        chk_pending1 = 1'b0;
        chk_pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == chk_add1)) chk_pending1 = 1'b1;
            if (live_q[i] && (rd_q[i] == chk_add2)) chk_pending2 = 1'b1;
        end
        if (rf_write_q && (rf_add_q == chk_add1)) chk_pending1 = 1'b1;
        if (rf_write_q && (rf_add_q == chk_add2)) chk_pending2 = 1'b1;
        if (chk_add1 == '0) chk_pending1 = 1'b0;
        if (chk_add2 == '0) chk_pending2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_write_q <= 1'b0;
            rf_add_q   <= '0;
            rf_data_q  <= '0;
        end else begin
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_write_q <= rf_write_d;
            rf_add_q   <= rf_add_d;
            rf_data_q  <= rf_data_d;
            // Payload needs no reset: a slot is only ever read while live.
            if (push) begin
                rd_q[wr_ptr_q]   <= ld_rd;
                data_q[wr_ptr_q] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          rf_write;
    logic [AW-1:0] rf_write_add;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] chk_add1;
    logic [AW-1:0] chk_add2;
    logic          chk_pending1;
    logic          chk_pending2;
    logic [2:0]    fifo_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rf_write     (rf_write),
        .rf_write_add (rf_write_add),
        .rf_data      (rf_data),
        .chk_add1     (chk_add1),
        .chk_add2     (chk_add2),
        .chk_pending1 (chk_pending1),
        .chk_pending2 (chk_pending2),
        .fifo_count   (fifo_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check_val({tag, ".wr"},   64'(rf_write), 64'd1);
        check_val({tag, ".add"},  64'(rf_write_add), 64'(a));
        check_val({tag, ".data"}, 64'(rf_data), 64'(d));
    endtask

    logic [AW-1:0] exp_add [5];
    logic [DW-1:0] exp_dat [5];
    int            exp_cnt [5];

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; chk_add1 = '0; chk_add2 = '0;

        // 1: reset then idle
        repeat (2) tick();
        check_val("rst.wr",    64'(rf_write), 64'd0);
        check_val("rst.add",   64'(rf_write_add), 64'd0);
        check_val("rst.data",  64'(rf_data), 64'd0);
        check_val("rst.count", 64'(fifo_count), 64'd0);
        check_val("rst.ready", 64'(ld_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst.ready", 64'(ld_ready), 64'd1);

        // 2: ALU write, then ALU to x0
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        check_wr("alu5", 5'd5, 32'hDEADBEEF);
        alu_valid = 1'b0;
        tick();
        check_val("alu5.after.wr", 64'(rf_write), 64'd0);
        check_val("alu5.hold.add", 64'(rf_write_add), 64'd5);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        check_val("alu0.wr",   64'(rf_write), 64'd0);
        check_val("alu0.data", 64'(rf_data), 64'hDEADBEEF);
        alu_valid = 1'b0;

        // 3a: four back-to-back loads, each written two edges after accept
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                ld_valid = 1'b1; ld_rd = AW'(i + 1); ld_data = DW'(32'h11 * (i + 1));
            end else begin
                ld_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) check_wr($sformatf("ld%0d", i), AW'(i), DW'(32'h11 * i));
            else check_val($sformatf("ld.idle%0d.wr", i), 64'(rf_write), 64'd0);
            check_val($sformatf("ld.cnt%0d", i), 64'(fifo_count), (i >= 1 && i <= 3) || i == 0 ? 64'd1 : 64'd0);
        end

        // 3b: ALU holds the port while the FIFO fills
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = DW'(32'hA0 + c);
            ld_valid = 1'b1;
            if (c < 4) begin
                ld_rd = AW'(c + 1); ld_data = DW'(32'h11 * (c + 1));
            end else begin
                ld_rd = 5'd6; ld_data = 32'h66;
            end
            tick();
            check_wr($sformatf("fill%0d", c), 5'd10, DW'(32'hA0 + c));
            check_val($sformatf("fill%0d.cnt", c), 64'(fifo_count), (c < 3) ? 64'(c + 1) : 64'd4);
            check_val($sformatf("fill%0d.ready", c), 64'(ld_ready), (c < 3) ? 64'd1 : 64'd0);
        end
        alu_valid = 1'b0;
        exp_add = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h66};
        exp_cnt = '{3, 3, 2, 1, 0};
        for (int k = 0; k < 5; k++) begin
            tick();
            check_wr($sformatf("drain%0d", k), exp_add[k], exp_dat[k]);
            check_val($sformatf("drain%0d.cnt", k), 64'(fifo_count), 64'(exp_cnt[k]));
            if (k == 0) check_val("drain0.ready", 64'(ld_ready), 64'd1);
            if (k == 1) ld_valid = 1'b0;
        end
        tick();
        check_val("drain.idle.wr", 64'(rf_write), 64'd0);

        // 4: kill a buffered load with a younger ALU write
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h90;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h70;
        tick();
        check_wr("kill.alu9", 5'd9, 32'h90);
        check_val("kill.cnt0", 64'(fifo_count), 64'd1);
        alu_rd = 5'd7; alu_data = 32'h99; ld_valid = 1'b0;
        tick();
        check_wr("kill.alu7", 5'd7, 32'h99);
        check_val("kill.cnt1", 64'(fifo_count), 64'd1);
        chk_add1 = 5'd7;
        #1;
        check_val("kill.pend", 64'(chk_pending1), 64'd1);
        alu_valid = 1'b0;
        tick();
        check_val("kill.pop.wr", 64'(rf_write), 64'd0);
        check_val("kill.pop.cnt", 64'(fifo_count), 64'd0);
        check_val("kill.pop.pend", 64'(chk_pending1), 64'd0);

        // 5: pending-write reporting
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        tick();
        ld_valid = 1'b0;
        chk_add1 = 5'd3; chk_add2 = 5'd0;
        #1;
        check_val("pend.live3", 64'(chk_pending1), 64'd1);
        check_val("pend.x0",    64'(chk_pending2), 64'd0);
        chk_add2 = 5'd12;
        #1;
        check_val("pend.rf12", 64'(chk_pending2), 64'd1);
        chk_add2 = 5'd4;
        #1;
        check_val("pend.none4", 64'(chk_pending2), 64'd0);
        alu_valid = 1'b0;
        tick();
        check_wr("pend.wr3", 5'd3, 32'h33);
        check_val("pend.inflight", 64'(chk_pending1), 64'd1);
        tick();
        check_val("pend.done.wr", 64'(rf_write), 64'd0);
        check_val("pend.done",    64'(chk_pending1), 64'd0);

        // 6: reset with three entries buffered
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD0;
        for (int j = 0; j < 3; j++) begin
            ld_valid = 1'b1; ld_rd = AW'(j + 1); ld_data = DW'(32'h100 + j);
            tick();
        end
        check_val("mid.cnt", 64'(fifo_count), 64'd3);
        rst = 1'b1; alu_valid = 1'b0; ld_rd = 5'd5;
        #1;
        check_val("mid.rst.ready", 64'(ld_ready), 64'd0);
        tick();
        check_val("mid.rst.cnt", 64'(fifo_count), 64'd0);
        check_val("mid.rst.wr",  64'(rf_write), 64'd0);
        check_val("mid.rst.add", 64'(rf_write_add), 64'd0);
        rst = 1'b0; ld_valid = 1'b0;
        #1;
        check_val("mid.ready", 64'(ld_ready), 64'd1);
        for (int j = 0; j < 3; j++) begin
            tick();
            check_val($sformatf("mid.after%0d.wr", j), 64'(rf_write), 64'd0);
            check_val($sformatf("mid.after%0d.cnt", j), 64'(fifo_count), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
